// File: rtl/cbus_arbiter.sv
// cbus_arbiter: round-robin two-master CBus arbiter with one transaction in flight and fixed read latency
module cbus_arbiter #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_wen,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_din,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_dout,
    input  logic              m1_req,
    input  logic              m1_wen,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_din,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_dout,
    output logic              cbus_en,
    output logic              cbus_wen,
    output logic [ADDR_W-1:0] cbus_addr,
    output logic [DATA_W-1:0] cbus_din,
    input  logic [DATA_W-1:0] cbus_dout,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);
    state_t            state_q, state_d;
    logic              gnt_q, gnt_d, last_gnt_q, last_gnt_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              cbus_en_q, cbus_en_d, cbus_wen_q, cbus_wen_d;
    logic [ADDR_W-1:0] cbus_addr_q, cbus_addr_d;
    logic [DATA_W-1:0] cbus_din_q, cbus_din_d;
    logic              m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
    logic [DATA_W-1:0] m0_dout_q, m0_dout_d, m1_dout_q, m1_dout_d;
    logic              busy_q, busy_d;
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_gnt_d  = last_gnt_q;
        cnt_d       = cnt_q;
        cbus_en_d   = 1'b0;
        cbus_wen_d  = cbus_wen_q;
        cbus_addr_d = cbus_addr_q;
        cbus_din_d  = cbus_din_q;
        m0_ack_d    = 1'b0;
        m1_ack_d    = 1'b0;
        m0_dout_d   = m0_dout_q;
        m1_dout_d   = m1_dout_q;
        case (state_q)
            IDLE: if (m0_req || m1_req) begin
                state_d     = ISSUE;
                gnt_d       = (m0_req && m1_req) ? ~last_gnt_q : m1_req;
                cbus_en_d   = 1'b1;
                cbus_wen_d  = gnt_d ? m1_wen : m0_wen;
                cbus_addr_d = gnt_d ? m1_addr : m0_addr;
                cbus_din_d  = gnt_d ? m1_din : m0_din;
            end
            ISSUE: if (cbus_wen_q) begin
                state_d  = DONE;
                m0_ack_d = ~gnt_q;
                m1_ack_d = gnt_q;
            end else begin
                state_d = WAIT;
                cnt_d   = CNT_INIT;
            end
            WAIT: if (cnt_q == 4'd0) begin
                state_d   = DONE;
                m0_ack_d  = ~gnt_q;
                m1_ack_d  = gnt_q;
                m0_dout_d = gnt_q ? m0_dout_q : cbus_dout;
                m1_dout_d = gnt_q ? cbus_dout : m1_dout_q;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            DONE: begin
                state_d    = IDLE;
                last_gnt_d = gnt_q;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end
    // last_gnt resets to m1 so the first tie goes to m0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            last_gnt_q  <= 1'b1;
            cnt_q       <= 4'd0;
            cbus_en_q   <= 1'b0;
            cbus_wen_q  <= 1'b0;
            cbus_addr_q <= '0;
            cbus_din_q  <= '0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m0_dout_q   <= '0;
            m1_dout_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_gnt_q  <= last_gnt_d;
            cnt_q       <= cnt_d;
            cbus_en_q   <= cbus_en_d;
            cbus_wen_q  <= cbus_wen_d;
            cbus_addr_q <= cbus_addr_d;
            cbus_din_q  <= cbus_din_d;
            m0_ack_q    <= m0_ack_d;
            m1_ack_q    <= m1_ack_d;
            m0_dout_q   <= m0_dout_d;
            m1_dout_q   <= m1_dout_d;
            busy_q      <= busy_d;
        end
    end
    assign cbus_en   = cbus_en_q;
    assign cbus_wen  = cbus_wen_q;
    assign cbus_addr = cbus_addr_q;
    assign cbus_din  = cbus_din_q;
    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign m0_dout   = m0_dout_q;
    assign m1_dout   = m1_dout_q;
    assign busy      = busy_q;
endmodule
